dii_instr_feeder: RTL and testbench

// - Upstream stage of the DII instruction-injection path: buffers 32-bit instruction words from the
//   UVM sequence driver and presents them to the core's DII fetch port, popping one word per instr_ack.
// - Throttles injection with a credit counter: fed-but-not-retired instructions (retire = rvfi_valid)
//   are capped at MaxInflight. Keeps the instr_in/instr_out counters in RTL for scoreboard checks.

---
 rtl/dii_feeder_pkg.sv | 9 +
 rtl/dii_fifo.sv | 74 +++++++
 rtl/dii_instr_feeder.sv | 122 ++++++++++++
 tb/tb_dii_instr_feeder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dii_feeder_pkg.sv
// Shared types and constants for the DII instruction feeder.
package dii_feeder_pkg;

  typedef logic [31:0] instr_word_t;

  // RISC-V canonical NOP (addi x0, x0, 0)
  localparam instr_word_t NopInstr = 32'h0000_0013;

endpackage : dii_feeder_pkg

// File: rtl/dii_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head word is valid whenever empty_o=0.
module dii_fifo
  import dii_feeder_pkg::*;
#(
  parameter int Depth = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  instr_word_t                data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output instr_word_t                data_o,
  output logic [$clog2(Depth+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int LW = $clog2(Depth + 1);
  localparam int PW = $clog2(Depth);
  localparam logic [LW-1:0] DepthL = LW'(Depth);

  instr_word_t   mem_q [Depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == DepthL);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_i && !empty_o && !flush_i;
    do_push  = push_i && !flush_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : dii_fifo

// File: rtl/dii_instr_feeder.sv
// Buffers driver instruction words and feeds the core DII port under an inflight-credit limit.
// Optional build macro DII_FEEDER_NOP_FILL_EN: present NOPs whenever the FIFO is empty and credit allows.
module dii_instr_feeder
  import dii_feeder_pkg::*;
#(
  parameter int Depth       = 8,
  parameter int MaxInflight = 16,
  parameter int CntW        = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_valid_i,
  output logic                             push_ready_o,
  input  instr_word_t                      push_instr_i,
  output logic                             instr_valid_o,
  output instr_word_t                      instr_rdata_dii_o,
  input  logic                             instr_ack_i,
  input  logic                             rvfi_valid_i,
  input  logic                             count_en_i,
  input  logic                             flush_i,
  output logic [CntW-1:0]                  instr_in_o,
  output logic [CntW-1:0]                  instr_out_o,
  output logic [$clog2(MaxInflight+1)-1:0] inflight_o,
  output logic [$clog2(Depth+1)-1:0]       level_o,
  output logic                             ack_miss_o,
  output logic                             underflow_o
);

  localparam int IW = $clog2(MaxInflight + 1);
  localparam logic [IW-1:0] MaxInfl = IW'(MaxInflight);

  instr_word_t   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          credit_ok;
  logic          pop;

  logic [IW-1:0]   inflight_q, inflight_d;
  logic [CntW-1:0] instr_in_q, instr_in_d;
  logic [CntW-1:0] instr_out_q, instr_out_d;
  logic            ack_miss_q, ack_miss_d;
  logic            underflow_q, underflow_d;

  dii_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (push_instr_i),
    .pop_i   (fifo_pop),
    .flush_i (flush_i),
    .data_o  (fifo_head),
    .level_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    credit_ok = (inflight_q < MaxInfl);
`ifdef DII_FEEDER_NOP_FILL_EN
    instr_valid_o     = credit_ok;
    instr_rdata_dii_o = fifo_empty ? NopInstr : fifo_head;
`else
    instr_valid_o     = !fifo_empty && credit_ok;
    instr_rdata_dii_o = fifo_empty ? '0 : fifo_head;
`endif
    // A flush swallows the ack: nothing is consumed or counted that cycle.
    pop          = instr_ack_i && instr_valid_o && !flush_i;
    fifo_pop     = pop && !fifo_empty;
    push_ready_o = !flush_i && (!fifo_full || fifo_pop);
    fifo_push    = push_valid_i && push_ready_o;
  end

  always_comb begin
    inflight_d  = inflight_q;
    instr_in_d  = instr_in_q;
    instr_out_d = instr_out_q;
    ack_miss_d  = ack_miss_q;
    underflow_d = underflow_q;

    if (instr_ack_i && !instr_valid_o) ack_miss_d = 1'b1;
    if (rvfi_valid_i && (inflight_q == '0)) underflow_d = 1'b1;
    if (rvfi_valid_i) instr_out_d = instr_out_q + CntW'(1);
    if (pop && count_en_i) instr_in_d = instr_in_q + CntW'(1);

    if (flush_i) begin
      inflight_d = '0;
    end else begin
      case ({pop, rvfi_valid_i})
        2'b10:   inflight_d = inflight_q + IW'(1);
        2'b01:   inflight_d = (inflight_q == '0) ? '0 : inflight_q - IW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q  <= '0;
      instr_in_q  <= '0;
      instr_out_q <= '0;
      ack_miss_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      instr_in_q  <= instr_in_d;
      instr_out_q <= instr_out_d;
      ack_miss_q  <= ack_miss_d;
      underflow_q <= underflow_d;
    end
  end

  assign inflight_o  = inflight_q;
  assign instr_in_o  = instr_in_q;
  assign instr_out_o = instr_out_q;
  assign ack_miss_o  = ack_miss_q;
  assign underflow_o = underflow_q;

endmodule : dii_instr_feeder

// File: tb/tb_dii_instr_feeder.sv
// Scoreboard bench for dii_instr_feeder: stimulus queues expected words, a monitor checks each pop.
module tb_dii_instr_feeder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_instr_i;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_dii_o;
  logic        instr_ack_i;
  logic        rvfi_valid_i;
  logic        count_en_i;
  logic        flush_i;
  logic [31:0] instr_in_o;
  logic [31:0] instr_out_o;
  logic [4:0]  inflight_o;
  logic [3:0]  level_o;
  logic        ack_miss_o;
  logic        underflow_o;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          pop_cnt = 0;
  logic [31:0] exp_q [$];
  logic        rdy_seen;

  dii_instr_feeder #(
    .Depth       (8),
    .MaxInflight (16),
    .CntW        (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .push_valid_i      (push_valid_i),
    .push_ready_o      (push_ready_o),
    .push_instr_i      (push_instr_i),
    .instr_valid_o     (instr_valid_o),
    .instr_rdata_dii_o (instr_rdata_dii_o),
    .instr_ack_i       (instr_ack_i),
    .rvfi_valid_i      (rvfi_valid_i),
    .count_en_i        (count_en_i),
    .flush_i           (flush_i),
    .instr_in_o        (instr_in_o),
    .instr_out_o       (instr_out_o),
    .inflight_o        (inflight_o),
    .level_o           (level_o),
    .ack_miss_o        (ack_miss_o),
    .underflow_o       (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock of stimulus; accepted pushes enter the scoreboard after the edge.
  task automatic drive(input logic pv, input logic [31:0] w, input logic ack,
                       input logic rv, input logic fl, output logic acc);
    push_valid_i = pv;
    push_instr_i = w;
    instr_ack_i  = ack;
    rvfi_valid_i = rv;
    flush_i      = fl;
    #2;
    rdy_seen = push_ready_o;
    acc      = pv && push_ready_o;
    if (fl) exp_q.delete();
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(w);
    push_valid_i = 1'b0;
    instr_ack_i  = 1'b0;
    rvfi_valid_i = 1'b0;
    flush_i      = 1'b0;
    #1;
  endtask

  // Monitor: every consumed word must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && instr_valid_o && instr_ack_i && !flush_i) begin
      pop_cnt++;
      if (exp_q.size() > 0) begin
        chk("pop_data", instr_rdata_dii_o, exp_q.pop_front());
      end else begin
`ifdef DII_FEEDER_NOP_FILL_EN
        chk("nop_data", instr_rdata_dii_o, NOP);
`else
        n_chk++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%08h expected no pop", instr_rdata_dii_o);
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   pushed;
    int   pops0;

    rst = 1'b1;
    push_valid_i = 1'b0;
    push_instr_i = '0;
    instr_ack_i  = 1'b0;
    rvfi_valid_i = 1'b0;
    count_en_i   = 1'b1;
    flush_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    chk("rst_level",     32'(level_o), 0);
    chk("rst_inflight",  32'(inflight_o), 0);
    chk("rst_instr_in",  instr_in_o, 0);
    chk("rst_instr_out", instr_out_o, 0);
    chk("rst_ready",     32'(push_ready_o), 1);
    chk("rst_ack_miss",  32'(ack_miss_o), 0);
    chk("rst_underflow", 32'(underflow_o), 0);
`ifndef DII_FEEDER_NOP_FILL_EN
    chk("rst_valid",     32'(instr_valid_o), 0);
    chk("rst_rdata",     instr_rdata_dii_o, 0);
`endif

    // Three words, then one ack per cycle
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hA000_0001 + 32'(i), 1'b0, 1'b0, 1'b0, acc);
    chk("abc_level", 32'(level_o), 3);
    chk("abc_valid", 32'(instr_valid_o), 1);
    chk("abc_head",  instr_rdata_dii_o, 32'hA000_0001);
    for (int i = 0; i < 3; i++) drive(1'b0, 0, instr_valid_o, 1'b0, 1'b0, acc);
    chk("abc_in",       instr_in_o, 3);
    chk("abc_level0",   32'(level_o), 0);
    chk("abc_inflight", 32'(inflight_o), 3);
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 1'b0, 1'b1, 1'b0, acc);
    chk("ret_inflight", 32'(inflight_o), 0);
    chk("ret_out",      instr_out_o, 3);

    // Retire with nothing inflight
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0, acc);
    chk("uf_flag",     32'(underflow_o), 1);
    chk("uf_inflight", 32'(inflight_o), 0);
    chk("uf_out",      instr_out_o, 4);

    // Credit limit: 20 words offered, acks whenever valid, no retire
    pushed = 0;
    pops0  = pop_cnt;
    for (int c = 0; c < 40; c++) begin
      drive(pushed < 20, 32'hC000_0000 + 32'(pushed), instr_valid_o, 1'b0, 1'b0, acc);
      if (acc) pushed++;
    end
    chk("cr_pushed",   32'(pushed), 20);
    chk("cr_pops",     32'(pop_cnt - pops0), 16);
    chk("cr_valid",    32'(instr_valid_o), 0);
    chk("cr_inflight", 32'(inflight_o), 16);
    chk("cr_level",    32'(level_o), 4);
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0, acc);
    chk("cr_rel_inflight", 32'(inflight_o), 15);
    chk("cr_rel_valid",    32'(instr_valid_o), 1);
    drive(1'b0, 0, instr_valid_o, 1'b0, 1'b0, acc);
    chk("cr_pops2",     32'(pop_cnt - pops0), 17);
    chk("cr_inflight2", 32'(inflight_o), 16);
    chk("cr_level2",    32'(level_o), 3);
    for (int i = 0; i < 16; i++) drive(1'b0, 0, 1'b0, 1'b1, 1'b0, acc);
    chk("cr_drain_inflight", 32'(inflight_o), 0);
    chk("cr_out", instr_out_o, 21);
    chk("cr_in",  instr_in_o, 20);

    // Flush with level 5, inflight 3 and a concurrent push+ack
    for (int i = 0; i < 3; i++) drive(1'b0, 0, instr_valid_o, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) drive(1'b1, 32'hF000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, acc);
    chk("fl_pre_level",    32'(level_o), 5);
    chk("fl_pre_inflight", 32'(inflight_o), 3);
    chk("fl_pre_in",       instr_in_o, 23);
    drive(1'b1, 32'hF0F0_F0F0, instr_valid_o, 1'b0, 1'b1, acc);
    chk("fl_ready",    32'(rdy_seen), 0);
    chk("fl_level",    32'(level_o), 0);
    chk("fl_inflight", 32'(inflight_o), 0);
    chk("fl_in",       instr_in_o, 23);
    chk("fl_out",      instr_out_o, 21);

    // Full FIFO: blocked alone, accepted alongside a pop
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, acc);
    chk("full_level", 32'(level_o), 8);
    drive(1'b1, 32'hBAD0_0000, 1'b0, 1'b0, 1'b0, acc);
    chk("full_ready0", 32'(rdy_seen), 0);
    chk("full_level2", 32'(level_o), 8);
    drive(1'b1, 32'hB000_0008, instr_valid_o, 1'b0, 1'b0, acc);
    chk("full_ready1", 32'(rdy_seen), 1);
    chk("full_level3", 32'(level_o), 8);
    chk("full_in",     instr_in_o, 24);

    // Drain with counting disabled
    count_en_i = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b0, 0, instr_valid_o, 1'b0, 1'b0, acc);
    chk("noc_in",       instr_in_o, 24);
    chk("noc_inflight", 32'(inflight_o), 9);
    chk("noc_level",    32'(level_o), 0);
    chk("noc_queue",    32'(exp_q.size()), 0);
    chk("pre_ack_miss", 32'(ack_miss_o), 0);

    // Ack on an empty FIFO
`ifdef DII_FEEDER_NOP_FILL_EN
    chk("nop_valid", 32'(instr_valid_o), 1);
    chk("nop_rdata", instr_rdata_dii_o, NOP);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
    chk("nop_inflight", 32'(inflight_o), 10);
    chk("nop_ack_miss", 32'(ack_miss_o), 0);
`else
    chk("empty_valid", 32'(instr_valid_o), 0);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
    chk("empty_ack_miss", 32'(ack_miss_o), 1);
    chk("empty_inflight", 32'(inflight_o), 9);
`endif
    chk("end_underflow", 32'(underflow_o), 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_dii_instr_feeder
